// File: rtl/piece_scan_pkg.sv
// Shared types for the piecewise 2D address scan: FSM states and the latched frame configuration.
package piece_scan_pkg;

   localparam int unsigned PSC_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_e;

   typedef struct packed {
      logic [PSC_WIDTH-1:0] x_max;
      logic [PSC_WIDTH-1:0] y_max;
      logic [PSC_WIDTH-1:0] i0_piece;
      logic [PSC_WIDTH-1:0] i1_piece;
      logic [PSC_WIDTH-1:0] x_stride_0;
      logic [PSC_WIDTH-1:0] x_stride_1;
      logic [PSC_WIDTH-1:0] y_stride_0;
      logic [PSC_WIDTH-1:0] y_stride_1;
      logic [PSC_WIDTH-1:0] offset_0;
      logic [PSC_WIDTH-1:0] offset_1;
      logic [PSC_WIDTH-1:0] offset_2;
      logic [PSC_WIDTH-1:0] offset_3;
   } cfg_t;

endpackage

// File: rtl/piece_addr_calc.sv
// Combinational piecewise-affine address: x*sx + y*sy + quadrant offset, all mod 2^WIDTH.
module piece_addr_calc
   import piece_scan_pkg::*;
#(
   parameter int unsigned WIDTH = PSC_WIDTH
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  cfg_t             cfg,
   output logic [WIDTH-1:0] addr
);

   logic             x_hi;
   logic             y_hi;
   logic [WIDTH-1:0] sx;
   logic [WIDTH-1:0] sy;
   logic [WIDTH-1:0] off;
   logic [WIDTH-1:0] px;
   logic [WIDTH-1:0] py;

   always_comb begin
      x_hi = (x >= cfg.i0_piece);
      y_hi = (y >= cfg.i1_piece);
      sx   = x_hi ? cfg.x_stride_1 : cfg.x_stride_0;
      sy   = y_hi ? cfg.y_stride_1 : cfg.y_stride_0;
      case ({x_hi, y_hi})
         2'b00:   off = cfg.offset_0;
         2'b01:   off = cfg.offset_1;
         2'b10:   off = cfg.offset_2;
         default: off = cfg.offset_3;
      endcase
      px   = x * sx;
      py   = y * sy;
      addr = px + py + off;
   end

endmodule

// File: rtl/piece_scan_ctrl.sv
// Frame sequencer: latches a config, scans x (inner) / y (outer) and streams one address per
// handshake through a single backpressured output register, pulsing done when the frame drains.
module piece_scan_ctrl
   import piece_scan_pkg::*;
#(
   parameter int unsigned WIDTH = PSC_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] x_max,
   input  logic [WIDTH-1:0] y_max,
   input  logic [WIDTH-1:0] i0_piece,
   input  logic [WIDTH-1:0] i1_piece,
   input  logic [WIDTH-1:0] x_stride_0,
   input  logic [WIDTH-1:0] x_stride_1,
   input  logic [WIDTH-1:0] y_stride_0,
   input  logic [WIDTH-1:0] y_stride_1,
   input  logic [WIDTH-1:0] offset_0,
   input  logic [WIDTH-1:0] offset_1,
   input  logic [WIDTH-1:0] offset_2,
   input  logic [WIDTH-1:0] offset_3,
   input  logic             abort,
   output logic             addr_valid,
   input  logic             addr_ready,
   output logic [WIDTH-1:0] addr_out,
   output logic             addr_last,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   cfg_t             cfg_q, cfg_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] calc_addr;
   logic             x_wrap;
   logic             at_last;

   piece_addr_calc #(.WIDTH(WIDTH)) u_addr_calc (
      .x    (x_q),
      .y    (y_q),
      .cfg  (cfg_q),
      .addr (calc_addr)
   );

   always_comb begin
      state_d = state_q;
      cfg_d   = cfg_q;
      x_d     = x_q;
      y_d     = y_q;
      addr_d  = addr_q;
      valid_d = valid_q;
      last_d  = last_q;
      x_wrap  = (x_q == cfg_q.x_max - WIDTH'(1));
      at_last = x_wrap && (y_q == cfg_q.y_max - WIDTH'(1));

      case (state_q)
         IDLE: begin
            if (cfg_valid) begin
               cfg_d.x_max      = x_max;
               cfg_d.y_max      = y_max;
               cfg_d.i0_piece   = i0_piece;
               cfg_d.i1_piece   = i1_piece;
               cfg_d.x_stride_0 = x_stride_0;
               cfg_d.x_stride_1 = x_stride_1;
               cfg_d.y_stride_0 = y_stride_0;
               cfg_d.y_stride_1 = y_stride_1;
               cfg_d.offset_0   = offset_0;
               cfg_d.offset_1   = offset_1;
               cfg_d.offset_2   = offset_2;
               cfg_d.offset_3   = offset_3;
               x_d              = '0;
               y_d              = '0;
               state_d          = (x_max == '0 || y_max == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            // Abort wins over a simultaneous handshake: nothing is loaded in that cycle.
            if (abort) begin
               state_d = IDLE;
               valid_d = 1'b0;
               last_d  = 1'b0;
            end else if (!valid_q || addr_ready) begin
               addr_d  = calc_addr;
               valid_d = 1'b1;
               last_d  = at_last;
               if (at_last) begin
                  state_d = DRAIN;
               end else if (x_wrap) begin
                  x_d = '0;
                  y_d = y_q + WIDTH'(1);
               end else begin
                  x_d = x_q + WIDTH'(1);
               end
            end
         end
         DRAIN: begin
            if (abort || addr_ready) begin
               state_d = abort ? IDLE : DONE;
               valid_d = 1'b0;
               last_d  = 1'b0;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cfg_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         addr_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         x_q     <= x_d;
         y_q     <= y_d;
         addr_q  <= addr_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign cfg_ready  = (state_q == IDLE);
   assign busy       = (state_q == RUN) || (state_q == DRAIN);
   assign done       = (state_q == DONE);
   assign addr_valid = valid_q;
   assign addr_out   = addr_q;
   assign addr_last  = last_q;

endmodule
